ghist_fold: RTL and testbench
=============================

Name: ghist_fold

Overview:
- Global branch-history register plus folded-history generator; directly upstream of dtage.
- Produces the four compressed history vectors h[0..3] that dtage uses with pc to index and tag its tagged tables.
- Updated once per resolved branch.
- Supports a full-history restore after a misprediction; a sequential rebuild then regenerates all folds before histories are declared valid.

Parameters:
- GHR_LEN, 64, global history length in bits; must equal L3.
- FOLD_W, 16, width of each folded history; matches dtage h[k] width.
- L0, 8, history length folded into h0.
- L1, 16, history length folded into h1.
- L2, 32, history length folded into h2.
- L3, 64, history length folded into h3.
- Constraint: L0 < L1 < L2 < L3 = GHR_LEN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- upd_valid  in  1  resolved-branch outcome present this cycle.
- upd_taken  in  1  outcome: 1 = taken.
- upd_ready  out  1  high when an update is accepted (state IDLE).
- rst_valid  in  1  restore request.
- rst_ghr  in  GHR_LEN  history to restore; bit 0 = newest.
- ghr  out  GHR_LEN  current global history; bit 0 = newest.
- h_flat  out  4*FOLD_W  folded histories; h[k] = h_flat[FOLD_W*k +: FOLD_W].
- hist_valid  out  1  high when h_flat and ghr are consistent (state IDLE).

Behaviour:
- Fold definition, always true when hist_valid = 1: h[k][p] = XOR of ghr[j] for j in 0..Lk-1 with (j mod FOLD_W) == p.
- Reset: ghr = 0, all folds = 0, state = IDLE, upd_ready = 1, hist_valid = 1. Reset asserted mid-rebuild aborts to these values.
- States are IDLE and REBUILD. Outputs: upd_ready = hist_valid = (state == IDLE), decoded combinationally from state.
- Update, IDLE, upd_valid = 1, rst_valid = 0:
  - ghr <= {ghr[GHR_LEN-2:0], upd_taken}.
  - Each fold: f <= rotl(f,1) ^ upd_taken at bit 0 ^ (ghr[Lk-1] << (Lk mod FOLD_W)).
  - New values are visible on ghr and h_flat after the edge (1-cycle latency). No combinational path from inputs to outputs.
- Restore, rst_valid = 1, any state:
  - Has priority over upd_valid in the same cycle; the update is dropped.
  - ghr <= rst_ghr, folds <= 0, cnt <= GHR_LEN-1, state <= REBUILD.
  - A restore arriving during REBUILD restarts the rebuild.
- REBUILD, one bit per cycle, oldest first:
  - Every fold: f <= rotl(f,1) ^ (cnt < Lk ? ghr[cnt] : 0) at bit 0. No eviction.
  - cnt decrements; at the edge where cnt == 0, state <= IDLE.
  - hist_valid is therefore low for exactly GHR_LEN cycles after the restore edge.
  - upd_valid during REBUILD is ignored (upd_ready = 0); upstream must hold or replay.
- Width rules: rotl is within FOLD_W. The eviction position (Lk mod FOLD_W) is an elaboration-time constant.
- Wrap-around: none beyond the implicit shift-out of ghr[GHR_LEN-1].

Test Plan:
- Reset → ghr = 0; h_flat = 0; upd_ready = hist_valid = 1.
- One update, taken → next cycle ghr = 0x1; h0 = h1 = h2 = h3 = 0x0001.
- 9 consecutive taken updates → ghr = 0x1FF; h0 = 0x00FF (eviction at L0); h1 = h2 = h3 = 0x01FF.
- 17 consecutive taken updates → h1 = 0xFFFF; h2 = 0xFFFE; h3 = 0xFFFE.
- Restore with rst_ghr = all-ones, upd_valid held high throughout:
  - upd_ready and hist_valid are low for 64 cycles and updates are ignored.
  - Then ghr = all-ones, h0 = 0x00FF, h1 = 0xFFFF, h2 = 0x0000, h3 = 0x0000.
- Restore and update in the same cycle; rst asserted at cycle 30 of a rebuild; 10k random updates and restores:
  - Restore wins the simultaneous case.
  - Reset mid-rebuild returns all outputs to reset values.
  - In the random run, every cycle with hist_valid = 1 matches a reference model computing folds directly from ghr.

Source files
------------

// File: rtl/ghist_fold.sv
// ghist_fold: global branch-history register with four folded histories.
//
// Keeps the last GHR_LEN branch outcomes (bit 0 = newest) and four XOR-folded
// compressions h[k] of the newest Lk bits, where
//   h[k][p] = XOR of ghr[j] for j < Lk with (j mod FOLD_W) == p.
// The folds are maintained incrementally on every accepted update. After a
// restore they are rebuilt one history bit per cycle, oldest first, and the
// histories are reported valid again only once the rebuild is complete.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   upd_valid  resolved branch outcome present this cycle
//   upd_taken  outcome, 1 = taken
//   upd_ready  update accepted this cycle (IDLE)
//   rst_valid  restore request; beats a same-cycle update, legal in any state
//   rst_ghr    history to restore, bit 0 = newest
//   ghr        current global history, bit 0 = newest
//   h_flat     folded histories, h[k] = h_flat[FOLD_W*k +: FOLD_W]
//   hist_valid ghr and h_flat are consistent (IDLE)
//
// Handshake: an update transfers on a rising edge where upd_valid and
// upd_ready are both high and rst_valid is low. upd_valid seen while
// upd_ready is low is ignored; the upstream must hold or replay it. A restore
// has no ready and is always taken. There is no combinational path from any
// input to any output.
module ghist_fold #(
    parameter int GHR_LEN = 64,
    parameter int FOLD_W  = 16,
    parameter int L0      = 8,
    parameter int L1      = 16,
    parameter int L2      = 32,
    parameter int L3      = 64     // must equal GHR_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  upd_valid,
    input  logic                  upd_taken,
    output logic                  upd_ready,
    input  logic                  rst_valid,
    input  logic [GHR_LEN-1:0]    rst_ghr,
    output logic [GHR_LEN-1:0]    ghr,
    output logic [4*FOLD_W-1:0]   h_flat,
    output logic                  hist_valid
);

    localparam int CNT_W = $clog2(GHR_LEN);

    typedef enum logic {
        IDLE    = 1'b0,
        REBUILD = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [GHR_LEN-1:0]           ghr_q, ghr_d;
    logic [3:0][FOLD_W-1:0]       fold_q, fold_d;

    // Candidate next value of each fold for the two ways it can advance.
    logic [3:0][FOLD_W-1:0]       fold_upd;
    logic [3:0][FOLD_W-1:0]       fold_rb;

    for (genvar k = 0; k < 4; k++) begin : g_fold
        localparam int LK = (k == 0) ? L0 : (k == 1) ? L1 : (k == 2) ? L2 : L3;
        // Position where the bit leaving this fold's window lands after rotation.
        localparam int EV = LK % FOLD_W;

        logic [FOLD_W-1:0] rot;
        logic              evict;
        logic              in_rng;
        logic              rb_bit;

        assign rot   = {fold_q[k][FOLD_W-2:0], fold_q[k][FOLD_W-1]};
        assign evict = ghr_q[LK-1];

        // Shifting the history moves every contributing bit up one position,
        // which is a rotate of the fold; the new outcome enters at bit 0 and
        // the bit that falls out of the Lk window is cancelled where the
        // rotate carried it.
        assign fold_upd[k] = rot
                           ^ {{(FOLD_W-1){1'b0}}, upd_taken}
                           ^ (FOLD_W'(evict) << EV);

        // Rebuild replays history oldest first with nothing to evict; bits
        // older than this fold's window contribute nothing.
        assign in_rng      = int'(cnt_q) < LK;
        assign rb_bit      = in_rng & ghr_q[cnt_q];
        assign fold_rb[k]  = rot ^ {{(FOLD_W-1){1'b0}}, rb_bit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ghr_q   <= '0;
            fold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ghr_q   <= ghr_d;
            fold_q  <= fold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ghr_d   = ghr_q;
        fold_d  = fold_q;

        if (rst_valid) begin
            ghr_d   = rst_ghr;
            fold_d  = '0;
            cnt_d   = CNT_W'(GHR_LEN - 1);
            state_d = REBUILD;
        end else begin
            case (state_q)
                IDLE: begin
                    if (upd_valid) begin
                        ghr_d  = {ghr_q[GHR_LEN-2:0], upd_taken};
                        fold_d = fold_upd;
                    end
                end
                REBUILD: begin
                    fold_d = fold_rb;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign upd_ready  = (state_q == IDLE);
    assign hist_valid = (state_q == IDLE);
    assign ghr        = ghr_q;
    assign h_flat     = fold_q;

endmodule

// File: tb/tb_ghist_fold.sv
module tb_ghist_fold;

    localparam int GHR_LEN = 64;
    localparam int FOLD_W  = 16;

    logic                 clk;
    logic                 rst;
    logic                 upd_valid;
    logic                 upd_taken;
    logic                 upd_ready;
    logic                 rst_valid;
    logic [GHR_LEN-1:0]   rst_ghr;
    logic [GHR_LEN-1:0]   ghr;
    logic [4*FOLD_W-1:0]  h_flat;
    logic                 hist_valid;

    int n_checks;
    int n_fail;

    ghist_fold dut (
        .clk        (clk),
        .rst        (rst),
        .upd_valid  (upd_valid),
        .upd_taken  (upd_taken),
        .upd_ready  (upd_ready),
        .rst_valid  (rst_valid),
        .rst_ghr    (rst_ghr),
        .ghr        (ghr),
        .h_flat     (h_flat),
        .hist_valid (hist_valid)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        upd_valid = 1'b0;
        upd_taken = 1'b0;
        rst_valid = 1'b0;
        rst_ghr   = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic drive_updates(input int n, input logic taken);
        for (int i = 0; i < n; i++) begin
            upd_valid = 1'b1;
            upd_taken = taken;
            step();
        end
        upd_valid = 1'b0;
        upd_taken = 1'b0;
    endtask

    function automatic logic [FOLD_W-1:0] hk(input logic [4*FOLD_W-1:0] hf, input int k);
        return hf[FOLD_W*k +: FOLD_W];
    endfunction

    // Reference fold straight from the definition over the first len bits.
    function automatic logic [FOLD_W-1:0] fold_of(input logic [GHR_LEN-1:0] g, input int len);
        logic [FOLD_W-1:0] f;
        f = '0;
        for (int j = 0; j < len; j++) f[j % FOLD_W] ^= g[j];
        return f;
    endfunction

    function automatic logic [4*FOLD_W-1:0] folds_of(input logic [GHR_LEN-1:0] g);
        return {fold_of(g, 64), fold_of(g, 32), fold_of(g, 16), fold_of(g, 8)};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_checks++; if (ghr !== 64'h0) begin n_fail++; $display("FAIL reset_ghr got %h exp 0", ghr); end
        n_checks++; if (h_flat !== 64'h0) begin n_fail++; $display("FAIL reset_h got %h exp 0", h_flat); end
        n_checks++; if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", upd_ready); end
        n_checks++; if (hist_valid !== 1'b1) begin n_fail++; $display("FAIL reset_valid got %b exp 1", hist_valid); end
    endtask

    task automatic test_one_taken();
        apply_reset();
        drive_updates(1, 1'b1);
        n_checks++; if (ghr !== 64'h1) begin n_fail++; $display("FAIL one_ghr got %h exp 1", ghr); end
        n_checks++;
        if (h_flat !== 64'h0001_0001_0001_0001) begin
            n_fail++; $display("FAIL one_h got %h exp 0001000100010001", h_flat);
        end
    endtask

    task automatic test_nine_taken();
        apply_reset();
        drive_updates(9, 1'b1);
        n_checks++; if (ghr !== 64'h1FF) begin n_fail++; $display("FAIL nine_ghr got %h exp 1ff", ghr); end
        n_checks++; if (hk(h_flat, 0) !== 16'h00FF) begin n_fail++; $display("FAIL nine_h0 got %h exp 00ff", hk(h_flat, 0)); end
        n_checks++; if (hk(h_flat, 1) !== 16'h01FF) begin n_fail++; $display("FAIL nine_h1 got %h exp 01ff", hk(h_flat, 1)); end
        n_checks++; if (hk(h_flat, 2) !== 16'h01FF) begin n_fail++; $display("FAIL nine_h2 got %h exp 01ff", hk(h_flat, 2)); end
        n_checks++; if (hk(h_flat, 3) !== 16'h01FF) begin n_fail++; $display("FAIL nine_h3 got %h exp 01ff", hk(h_flat, 3)); end
    endtask

    task automatic test_seventeen_taken();
        apply_reset();
        drive_updates(17, 1'b1);
        n_checks++; if (ghr !== 64'h1FFFF) begin n_fail++; $display("FAIL s17_ghr got %h exp 1ffff", ghr); end
        n_checks++; if (hk(h_flat, 0) !== 16'h00FF) begin n_fail++; $display("FAIL s17_h0 got %h exp 00ff", hk(h_flat, 0)); end
        n_checks++; if (hk(h_flat, 1) !== 16'hFFFF) begin n_fail++; $display("FAIL s17_h1 got %h exp ffff", hk(h_flat, 1)); end
        n_checks++; if (hk(h_flat, 2) !== 16'hFFFE) begin n_fail++; $display("FAIL s17_h2 got %h exp fffe", hk(h_flat, 2)); end
        n_checks++; if (hk(h_flat, 3) !== 16'hFFFE) begin n_fail++; $display("FAIL s17_h3 got %h exp fffe", hk(h_flat, 3)); end
    endtask

    task automatic test_restore_all_ones();
        int low_valid;
        int low_ready;
        apply_reset();
        drive_updates(3, 1'b1);
        upd_valid = 1'b1;
        upd_taken = 1'b0;
        rst_valid = 1'b1;
        rst_ghr   = {GHR_LEN{1'b1}};
        step();
        rst_valid = 1'b0;
        rst_ghr   = '0;
        low_valid = 0;
        low_ready = 0;
        for (int i = 0; i < 64; i++) begin
            if (hist_valid === 1'b0) low_valid++;
            if (upd_ready === 1'b0) low_ready++;
            step();
        end
        n_checks++; if (low_valid != 64) begin n_fail++; $display("FAIL rb_valid_low_cycles got %0d exp 64", low_valid); end
        n_checks++; if (low_ready != 64) begin n_fail++; $display("FAIL rb_ready_low_cycles got %0d exp 64", low_ready); end
        n_checks++; if (hist_valid !== 1'b1) begin n_fail++; $display("FAIL rb_valid_after got %b exp 1", hist_valid); end
        n_checks++;
        if (ghr !== {GHR_LEN{1'b1}}) begin n_fail++; $display("FAIL rb_ghr got %h exp all ones", ghr); end
        n_checks++; if (hk(h_flat, 0) !== 16'h00FF) begin n_fail++; $display("FAIL rb_h0 got %h exp 00ff", hk(h_flat, 0)); end
        n_checks++; if (hk(h_flat, 1) !== 16'hFFFF) begin n_fail++; $display("FAIL rb_h1 got %h exp ffff", hk(h_flat, 1)); end
        n_checks++; if (hk(h_flat, 2) !== 16'h0000) begin n_fail++; $display("FAIL rb_h2 got %h exp 0000", hk(h_flat, 2)); end
        n_checks++; if (hk(h_flat, 3) !== 16'h0000) begin n_fail++; $display("FAIL rb_h3 got %h exp 0000", hk(h_flat, 3)); end
        upd_valid = 1'b0;
    endtask

    task automatic test_restore_wins();
        logic [GHR_LEN-1:0] v;
        v = 64'h0123_4567_89AB_CDEF;
        apply_reset();
        drive_updates(5, 1'b1);
        upd_valid = 1'b1;
        upd_taken = 1'b1;
        rst_valid = 1'b1;
        rst_ghr   = v;
        step();
        upd_valid = 1'b0;
        rst_valid = 1'b0;
        n_checks++; if (ghr !== v) begin n_fail++; $display("FAIL sim_ghr got %h exp %h", ghr, v); end
        n_checks++; if (hist_valid !== 1'b0) begin n_fail++; $display("FAIL sim_valid got %b exp 0", hist_valid); end
        for (int i = 0; i < 64; i++) step();
        n_checks++; if (hist_valid !== 1'b1) begin n_fail++; $display("FAIL sim_valid_after got %b exp 1", hist_valid); end
        n_checks++;
        if (h_flat !== folds_of(v)) begin n_fail++; $display("FAIL sim_h got %h exp %h", h_flat, folds_of(v)); end
        // Restore arriving mid-rebuild restarts the full rebuild.
        rst_valid = 1'b1;
        rst_ghr   = ~v;
        step();
        for (int i = 0; i < 20; i++) step();
        rst_valid = 1'b1;
        rst_ghr   = v;
        step();
        rst_valid = 1'b0;
        for (int i = 0; i < 63; i++) step();
        n_checks++; if (hist_valid !== 1'b0) begin n_fail++; $display("FAIL restart_valid got %b exp 0", hist_valid); end
        step();
        n_checks++; if (hist_valid !== 1'b1) begin n_fail++; $display("FAIL restart_valid_after got %b exp 1", hist_valid); end
        n_checks++;
        if (h_flat !== folds_of(v)) begin n_fail++; $display("FAIL restart_h got %h exp %h", h_flat, folds_of(v)); end
    endtask

    task automatic test_reset_mid_rebuild();
        apply_reset();
        rst_valid = 1'b1;
        rst_ghr   = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        rst_valid = 1'b0;
        for (int i = 0; i < 30; i++) step();
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (ghr !== 64'h0) begin n_fail++; $display("FAIL midrst_ghr got %h exp 0", ghr); end
        n_checks++; if (h_flat !== 64'h0) begin n_fail++; $display("FAIL midrst_h got %h exp 0", h_flat); end
        n_checks++; if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b exp 1", upd_ready); end
        n_checks++; if (hist_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_valid got %b exp 1", hist_valid); end
        step();
        rst = 1'b0;
        drive_updates(1, 1'b1);
        n_checks++; if (ghr !== 64'h1) begin n_fail++; $display("FAIL midrst_upd_ghr got %h exp 1", ghr); end
    endtask

    task automatic test_random();
        logic [GHR_LEN-1:0] m_ghr;
        int                 m_rem;
        int                 bad;
        apply_reset();
        m_ghr = '0;
        m_rem = 0;
        bad   = 0;
        for (int c = 0; c < 10000; c++) begin
            upd_valid = ($urandom_range(0, 3) != 0);
            upd_taken = $urandom_range(0, 1);
            rst_valid = ($urandom_range(0, 199) == 0);
            rst_ghr   = {$urandom, $urandom};
            // Model the edge about to happen.
            if (rst_valid) begin
                m_ghr = rst_ghr;
                m_rem = 64;
            end else if (m_rem > 0) begin
                m_rem--;
            end else if (upd_valid) begin
                m_ghr = {m_ghr[GHR_LEN-2:0], upd_taken};
            end
            step();
            n_checks++;
            if (hist_valid !== (m_rem == 0) || upd_ready !== (m_rem == 0)) begin
                n_fail++;
                if (bad < 5) $display("FAIL rnd_valid cyc %0d got %b/%b exp %b", c, hist_valid, upd_ready, m_rem == 0);
                bad++;
            end
            if (m_rem == 0) begin
                n_checks++;
                if (ghr !== m_ghr || h_flat !== folds_of(m_ghr)) begin
                    n_fail++;
                    if (bad < 5) $display("FAIL rnd_hist cyc %0d got %h %h exp %h %h", c, ghr, h_flat, m_ghr, folds_of(m_ghr));
                    bad++;
                end
            end
        end
        upd_valid = 1'b0;
        rst_valid = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        upd_valid = 1'b0;
        upd_taken = 1'b0;
        rst_valid = 1'b0;
        rst_ghr   = '0;
        test_reset();
        test_one_taken();
        test_nine_taken();
        test_seventeen_taken();
        test_restore_all_ones();
        test_restore_wins();
        test_reset_mid_rebuild();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
